// File: rtl/memory_responder_if.sv
// Memory-port bundle between the datapath (master) and the memory responder (slave).
interface memory_responder_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  mem_read;
    logic                  mem_write;
    logic [31:0]           addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  mem_ready;
    logic                  busy;
    logic                  mem_err;

    modport master (
        output mem_read, mem_write, addr, wdata,
        input  rdata, mem_ready, busy, mem_err
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata,
        output rdata, mem_ready, busy, mem_err
    );
endinterface

// File: rtl/memory_responder.sv
// Word-addressed memory with a fixed access latency, one-cycle completion/error pulses
// and registered outputs; requests are only sampled while idle.
module memory_responder #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LATENCY    = 2
) (
    input logic               clk,
    input logic               clr,
    memory_responder_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    op_wr_q, op_wr_d;
    logic                    oor_q, oor_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;
    logic                    merr_q, merr_d;
    logic                    mem_we_s;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    // Next-state and registered-output computation.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_wr_d  = op_wr_q;
        oor_d    = oor_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        ready_d  = 1'b0;
        merr_d   = 1'b0;
        busy_d   = busy_q;
        mem_we_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.mem_read && bus.mem_write) begin
                    // Conflicting strobes: skip the access, respond with an error next cycle.
                    state_d = ST_RESP;
                    ready_d = 1'b1;
                    merr_d  = 1'b1;
                    busy_d  = 1'b1;
                end else if (bus.mem_read || bus.mem_write) begin
                    op_wr_d = bus.mem_write;
                    addr_d  = bus.addr[ADDR_WIDTH-1:0];
                    oor_d   = |bus.addr[31:ADDR_WIDTH];
                    wdata_d = bus.wdata;
                    cnt_d   = 4'(LATENCY);
                    state_d = ST_WAIT;
                    busy_d  = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_RESP;
                    ready_d = 1'b1;
                    merr_d  = oor_q;
                    if (op_wr_q) begin
                        mem_we_s = ~oor_q;
                    end else if (oor_q) begin
                        rdata_d = {DATA_WIDTH{1'b0}};
                    end else begin
                        rdata_d = mem_q[addr_q];
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Control and output registers, asynchronously cleared.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            op_wr_q <= 1'b0;
            oor_q   <= 1'b0;
            addr_q  <= {ADDR_WIDTH{1'b0}};
            wdata_q <= {DATA_WIDTH{1'b0}};
            rdata_q <= {DATA_WIDTH{1'b0}};
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            merr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            oor_q   <= oor_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            merr_q  <= merr_d;
        end
    end

    // Storage array; contents deliberately survive clr.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    assign bus.rdata     = rdata_q;
    assign bus.mem_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.mem_err   = merr_q;
endmodule

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder with LATENCY=2 and LATENCY=0 instances.
module tb_memory_responder;
    logic clk = 1'b0;
    logic clr2 = 1'b1;
    logic clr0 = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    memory_responder_if #(.DATA_WIDTH(32)) bus2 ();
    memory_responder_if #(.DATA_WIDTH(32)) bus0 ();

    memory_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .LATENCY(2)) dut2 (
        .clk(clk), .clr(clr2), .bus(bus2)
    );
    memory_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .LATENCY(0)) dut0 (
        .clk(clk), .clr(clr0), .bus(bus0)
    );

    // Issue one request on the LATENCY=2 port and observe the response (k = negedges after accept edge).
    task automatic req2(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output int k_rdy, output logic err, output logic [31:0] rdat,
                        output logic busy_held, output logic busy_after);
        k_rdy = -1; err = 1'b0; rdat = 32'd0; busy_held = 1'b1;
        @(negedge clk);
        bus2.mem_read = rd; bus2.mem_write = wr; bus2.addr = a; bus2.wdata = d;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) begin bus2.mem_read = 1'b0; bus2.mem_write = 1'b0; end
            if (!bus2.busy) busy_held = 1'b0;
            if (bus2.mem_ready) begin
                k_rdy = k; err = bus2.mem_err; rdat = bus2.rdata;
                break;
            end
        end
        @(negedge clk);
        busy_after = bus2.busy;
    endtask

    task automatic req0(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output int k_rdy, output logic err, output logic [31:0] rdat);
        k_rdy = -1; err = 1'b0; rdat = 32'd0;
        @(negedge clk);
        bus0.mem_read = rd; bus0.mem_write = wr; bus0.addr = a; bus0.wdata = d;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 1) begin bus0.mem_read = 1'b0; bus0.mem_write = 1'b0; end
            if (bus0.mem_ready) begin
                k_rdy = k; err = bus0.mem_err; rdat = bus0.rdata;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        clr2 = 1'b1; clr0 = 1'b1;
        bus2.mem_read = 1'b1; bus2.mem_write = 1'b0; bus2.addr = 32'd0; bus2.wdata = 32'd0;
        bus0.mem_read = 1'b1; bus0.mem_write = 1'b0; bus0.addr = 32'd0; bus0.wdata = 32'd0;
        repeat (3) @(negedge clk);
        checks++; if (bus2.rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata2: got %h want 0", bus2.rdata); end
        checks++; if (bus2.mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready2: got %b want 0", bus2.mem_ready); end
        checks++; if (bus2.busy !== 1'b0) begin errors++; $display("FAIL reset_busy2: got %b want 0", bus2.busy); end
        checks++; if (bus2.mem_err !== 1'b0) begin errors++; $display("FAIL reset_err2: got %b want 0", bus2.mem_err); end
        checks++; if ({bus0.rdata, bus0.mem_ready, bus0.busy, bus0.mem_err} !== 35'd0) begin
            errors++; $display("FAIL reset_outs0: got %h want 0", {bus0.rdata, bus0.mem_ready, bus0.busy, bus0.mem_err});
        end
        bus2.mem_read = 1'b0; bus0.mem_read = 1'b0;
        clr2 = 1'b0; clr0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        int k; logic e, bh, ba; logic [31:0] r;
        req2(1'b0, 1'b1, 32'h5, 32'hDEADBEEF, k, e, r, bh, ba);
        checks++; if (k !== 4) begin errors++; $display("FAIL wr_latency: got %0d want 4", k); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL wr_err: got %b want 0", e); end
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL wr_rdata_unchanged: got %h want 0", r); end
        checks++; if (bh !== 1'b1 || ba !== 1'b0) begin errors++; $display("FAIL wr_busy: held %b after %b want 1/0", bh, ba); end
        req2(1'b1, 1'b0, 32'h5, 32'h0, k, e, r, bh, ba);
        checks++; if (k !== 4) begin errors++; $display("FAIL rd_latency: got %0d want 4", k); end
        checks++; if (r !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h want deadbeef", r); end
        checks++; if (e !== 1'b0 || bh !== 1'b1) begin errors++; $display("FAIL rd_err_busy: err %b busy %b want 0/1", e, bh); end
    endtask

    task automatic test_out_of_range();
        int k; logic e, bh, ba; logic [31:0] r;
        req2(1'b0, 1'b1, 32'h0, 32'h13579BDF, k, e, r, bh, ba);
        req2(1'b1, 1'b0, 32'h0000_0200, 32'h0, k, e, r, bh, ba);
        checks++; if (e !== 1'b1 || k !== 4) begin errors++; $display("FAIL oor_rd_err: err %b k %0d want 1/4", e, k); end
        checks++; if (r !== 32'd0) begin errors++; $display("FAIL oor_rd_data: got %h want 0", r); end
        req2(1'b0, 1'b1, 32'h0000_0200, 32'hFFFFFFFF, k, e, r, bh, ba);
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_wr_err: got %b want 1", e); end
        req2(1'b1, 1'b0, 32'h0, 32'h0, k, e, r, bh, ba);
        checks++; if (r !== 32'h13579BDF || e !== 1'b0) begin errors++; $display("FAIL oor_followup: data %h err %b want 13579bdf/0", r, e); end
    endtask

    task automatic test_both_strobes();
        int k; logic e, bh, ba; logic [31:0] r;
        req2(1'b0, 1'b1, 32'h7, 32'h00C0FFEE, k, e, r, bh, ba);
        req2(1'b1, 1'b1, 32'h7, 32'h1234, k, e, r, bh, ba);
        checks++; if (k !== 1 || e !== 1'b1) begin errors++; $display("FAIL both_err: k %0d err %b want 1/1", k, e); end
        checks++; if (r !== 32'h13579BDF) begin errors++; $display("FAIL both_rdata_hold: got %h want 13579bdf", r); end
        checks++; if (ba !== 1'b0) begin errors++; $display("FAIL both_busy_after: got %b want 0", ba); end
        req2(1'b1, 1'b0, 32'h7, 32'h0, k, e, r, bh, ba);
        checks++; if (r !== 32'h00C0FFEE) begin errors++; $display("FAIL both_no_write: got %h want 00c0ffee", r); end
    endtask

    task automatic test_busy_ignore();
        int k, pulses; logic e, bh, ba; logic [31:0] r, r_at;
        req2(1'b0, 1'b1, 32'h9, 32'h00000099, k, e, r, bh, ba);
        pulses = 0; r_at = 32'd0;
        @(negedge clk);
        bus2.mem_read = 1'b1; bus2.mem_write = 1'b0; bus2.addr = 32'h9; bus2.wdata = 32'h0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus2.mem_ready) begin pulses++; r_at = bus2.rdata; end
            if (bus2.busy && !bus2.mem_ready) begin
                bus2.mem_read = 1'b0; bus2.mem_write = i[0]; bus2.wdata = 32'hFFFF;
            end else begin
                bus2.mem_read = 1'b0; bus2.mem_write = 1'b0;
            end
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL busy_pulses: got %0d want 1", pulses); end
        checks++; if (r_at !== 32'h00000099) begin errors++; $display("FAIL busy_orig_read: got %h want 00000099", r_at); end
        req2(1'b1, 1'b0, 32'h9, 32'h0, k, e, r, bh, ba);
        checks++; if (r !== 32'h00000099) begin errors++; $display("FAIL busy_mem_unchanged: got %h want 00000099", r); end
    endtask

    task automatic test_reset_mid();
        int k, pulses; logic e, bh, ba; logic [31:0] r;
        req2(1'b0, 1'b1, 32'h3, 32'h33333333, k, e, r, bh, ba);
        req2(1'b1, 1'b0, 32'h9, 32'h0, k, e, r, bh, ba);
        @(negedge clk);
        bus2.mem_read = 1'b0; bus2.mem_write = 1'b1; bus2.addr = 32'h3; bus2.wdata = 32'hA5A5A5A5;
        @(negedge clk);
        bus2.mem_write = 1'b0;
        clr2 = 1'b1;
        #1;
        checks++; if ({bus2.rdata, bus2.mem_ready, bus2.busy, bus2.mem_err} !== 35'd0) begin
            errors++; $display("FAIL midrst_async_outs: got %h want 0", {bus2.rdata, bus2.mem_ready, bus2.busy, bus2.mem_err});
        end
        pulses = 0;
        repeat (2) @(negedge clk);
        clr2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus2.mem_ready) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_ready: got %0d pulses want 0", pulses); end
        req2(1'b1, 1'b0, 32'h3, 32'h0, k, e, r, bh, ba);
        checks++; if (r !== 32'h33333333) begin errors++; $display("FAIL midrst_mem_kept: got %h want 33333333", r); end
    endtask

    task automatic test_latency0();
        int k, pulses; logic e; logic [31:0] r, r2;
        req0(1'b0, 1'b1, 32'h1, 32'h11, k, e, r);
        checks++; if (k !== 2) begin errors++; $display("FAIL l0_wr_latency: got %0d want 2", k); end
        req0(1'b1, 1'b0, 32'h1, 32'h0, k, e, r);
        checks++; if (k !== 2 || r !== 32'h11 || e !== 1'b0) begin
            errors++; $display("FAIL l0_read: k %0d data %h err %b want 2/11/0", k, r, e);
        end
        // Hold the read strobe to get a second request accepted as soon as the port is idle again.
        req0(1'b0, 1'b1, 32'h2, 32'h22, k, e, r);
        @(negedge clk);
        bus0.mem_read = 1'b1; bus0.addr = 32'h2;
        pulses = 0; r2 = 32'd0;
        for (int i = 1; i <= 20 && pulses < 2; i++) begin
            @(negedge clk);
            if (bus0.mem_ready) begin pulses++; r2 = bus0.rdata; end
        end
        bus0.mem_read = 1'b0;
        checks++; if (pulses !== 2 || r2 !== 32'h22) begin
            errors++; $display("FAIL l0_back_to_back: pulses %0d data %h want 2/22", pulses, r2);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_out_of_range();
        test_both_strobes();
        test_busy_ignore();
        test_reset_mid();
        test_latency0();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
